// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin owner of the bit-serial bus, routing the granted master to its target slave.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   m_req/m_sid/m_mode/...     per-master request, target slave ID and serial signals
//   m_grant                    one-hot grant to the current owner
//   m_rd_bus/m_slave_*         slave returns routed to the owner, 0 elsewhere
//   s_mode/s_wr_bus/s_master_* owner signals routed to the selected slave, 0 elsewhere
//   s_rd_bus/s_slave_*         slave returns
//   busy, timeout, decode_err  status: bus owned/releasing, grant revoked, sid out of range
module serial_bus_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int NUM_SLAVES    = 3,
    parameter int GRANT_TIMEOUT = 16,
    localparam int SID_W        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_MASTERS-1:0]       m_req,
    input  logic [NUM_MASTERS*SID_W-1:0] m_sid,
    input  logic [NUM_MASTERS-1:0]       m_mode,
    input  logic [NUM_MASTERS-1:0]       m_wr_bus,
    input  logic [NUM_MASTERS-1:0]       m_valid,
    input  logic [NUM_MASTERS-1:0]       m_ready,
    output logic [NUM_MASTERS-1:0]       m_grant,
    output logic [NUM_MASTERS-1:0]       m_rd_bus,
    output logic [NUM_MASTERS-1:0]       m_slave_ready,
    output logic [NUM_MASTERS-1:0]       m_slave_valid,
    output logic [NUM_SLAVES-1:0]        s_mode,
    output logic [NUM_SLAVES-1:0]        s_wr_bus,
    output logic [NUM_SLAVES-1:0]        s_master_valid,
    output logic [NUM_SLAVES-1:0]        s_master_ready,
    input  logic [NUM_SLAVES-1:0]        s_rd_bus,
    input  logic [NUM_SLAVES-1:0]        s_slave_ready,
    input  logic [NUM_SLAVES-1:0]        s_slave_valid,
    output logic                         busy,
    output logic                         timeout,
    output logic                         decode_err
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(GRANT_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;
    state_t           state_q, state_d;
    logic [GW-1:0]    g_q, g_d, rr_q, rr_d, pick, idx;
    logic [SID_W-1:0] sid_q, sid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             found, active, sid_ok, route;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            g_q       <= '0;
            rr_q      <= GW'(NUM_MASTERS - 1);
            sid_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_q      <= rr_d;
            sid_q     <= sid_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    // First requester strictly after the last owner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = GW'((int'(rr_q) + k) % NUM_MASTERS);
            if (!found && m_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end
    // Request drop outranks valid, and valid outranks the timeout.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_d      = rr_q;
        sid_d     = sid_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d = GRANT;
                g_d     = pick;
                sid_d   = m_sid[pick*SID_W +: SID_W];
                cnt_d   = '0;
            end
            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (!m_req[g_q]) state_d = RELEASE;
                else if (m_valid[g_q]) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(GRANT_TIMEOUT - 1)) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            BUSY: if (!m_req[g_q]) state_d = RELEASE;
            RELEASE: begin
                rr_d    = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Routing is purely a function of registered owner/sid plus live lane signals.
    always_comb begin
        active         = (state_q == GRANT) || (state_q == BUSY);
        sid_ok         = int'(sid_q) < NUM_SLAVES;
        route          = active && sid_ok;
        m_grant        = active ? NUM_MASTERS'(1) << g_q : '0;
        s_mode         = route ? NUM_SLAVES'(m_mode[g_q]) << sid_q : '0;
        s_wr_bus       = route ? NUM_SLAVES'(m_wr_bus[g_q]) << sid_q : '0;
        s_master_valid = route ? NUM_SLAVES'(m_valid[g_q]) << sid_q : '0;
        s_master_ready = route ? NUM_SLAVES'(m_ready[g_q]) << sid_q : '0;
        m_rd_bus       = route ? NUM_MASTERS'(s_rd_bus[sid_q]) << g_q : '0;
        m_slave_ready  = route ? NUM_MASTERS'(s_slave_ready[sid_q]) << g_q : '0;
        m_slave_valid  = route ? NUM_MASTERS'(s_slave_valid[sid_q]) << g_q : '0;
        busy           = state_q != IDLE;
        timeout        = timeout_q;
        decode_err     = active && !sid_ok;
    end
endmodule
